// File: rtl/lut_ff_mux_bist.sv
`default_nettype none
// ============================================================================
//  Module   : lut_ff_mux_bist
//  Purpose  : Built-in self-test sequencer for a lut_ff_mux pair. It drives
//             the same stimulus into a reference (golden) instance and a
//             post-route (netlist) instance, then compares their Q outputs
//             once per vector. It applies 5 directed vectors (a reset vector
//             and four LUT/mux patterns) and then NUM_VECTORS pseudo-random
//             vectors taken from an 8-bit LFSR.
//  Ports    : clk          - sole clock, rising edge
//             rst_n        - asynchronous active-low reset
//             start        - run request, sampled only in IDLE or DONE
//             q_golden     - Q from the reference instance
//             q_netlist    - Q from the post-route instance
//             dut_rst      - active-high reset to both instances
//             stim_in      - in[3:0] to both instances
//             stim_mux_sel - mux_sel to both instances
//             busy         - run in progress
//             done         - run complete, held until next start or reset
//             pass         - done with zero mismatches
//             mismatch_cnt - saturating count of failed compares
//  Revision : 1.0 - initial release
// ============================================================================
module lut_ff_mux_bist #(
  parameter int         NUM_VECTORS = 100,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         MISMATCH_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  q_golden,
  input  logic                  q_netlist,
  output logic                  dut_rst,
  output logic [3:0]            stim_in,
  output logic                  stim_mux_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_VEC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int                    TOTAL_VECTORS = 5 + NUM_VECTORS;
  localparam logic [16:0]           LAST_VEC      = 17'(TOTAL_VECTORS - 1);
  localparam logic [16:0]           FIRST_RANDOM  = 17'd5;
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [7:0]            SEED_EFF      = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [MISMATCH_W-1:0] CNT_MAX       = '1;
  localparam logic [MISMATCH_W-1:0] CNT_ONE       = MISMATCH_W'(1);
  // Drain counter value seen on the fifth edge after the last compare.
  localparam logic [2:0]            DRAIN_LAST    = 3'd4;

  logic [1:0]  state;
  logic [16:0] vec_idx;
  logic        phase;      // 0: first cycle of a vector, 1: compare on next edge
  logic [2:0]  drain_cnt;
  logic [7:0]  lfsr;

  logic [7:0]  lfsr_next;
  logic [7:0]  lfsr_src;
  logic [16:0] vec_next;
  logic        cur_is_random;
  logic        miscompare;
  logic [3:0]  nxt_in;
  logic        nxt_sel;

  assign lfsr_next     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign vec_next      = vec_idx + 17'd1;
  assign cur_is_random = (vec_idx >= FIRST_RANDOM);
  assign miscompare    = q_golden ^ q_netlist;

  // The LFSR steps at the edge that ends a random vector, and that same edge
  // loads the next vector. The first random vector therefore uses the seed
  // as loaded, while later ones use the freshly stepped value.
  assign lfsr_src = cur_is_random ? lfsr_next : lfsr;

  // Stimulus for the vector that starts at the upcoming compare edge.
  always_comb begin
    nxt_in  = lfsr_src[3:0];
    nxt_sel = lfsr_src[4];
    case (vec_next)
      17'd1: begin nxt_in = 4'b0100; nxt_sel = 1'b0; end
      17'd2: begin nxt_in = 4'b0100; nxt_sel = 1'b1; end
      17'd3: begin nxt_in = 4'b0001; nxt_sel = 1'b0; end
      17'd4: begin nxt_in = 4'b0001; nxt_sel = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      vec_idx      <= '0;
      phase        <= 1'b0;
      drain_cnt    <= '0;
      lfsr         <= SEED;
      dut_rst      <= 1'b1;
      stim_in      <= '0;
      stim_mux_sel <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Vector 0 holds both instances in reset.
            state        <= ST_VEC;
            vec_idx      <= '0;
            phase        <= 1'b0;
            drain_cnt    <= '0;
            lfsr         <= SEED_EFF;
            dut_rst      <= 1'b1;
            stim_in      <= '0;
            stim_mux_sel <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
          end
        end

        ST_VEC: begin
          phase <= ~phase;
          if (phase) begin
            if (miscompare && (mismatch_cnt != CNT_MAX)) begin
              mismatch_cnt <= mismatch_cnt + CNT_ONE;
            end
            if (cur_is_random) begin
              lfsr <= lfsr_next;
            end
            if (vec_idx == LAST_VEC) begin
              // Last vector stays on the pins through the drain period.
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              vec_idx      <= vec_next;
              dut_rst      <= 1'b0;
              stim_in      <= nxt_in;
              stim_mux_sel <= nxt_sel;
            end
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mismatch_cnt == '0);
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lut_ff_mux_bist.md
LUT_FF_MUX_BIST -- requirements
Module: lut_ff_mux_bist

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 100: number of pseudo-random vectors applied after the directed vectors (range 1..65535).
REQ-002 SHALL have parameter SEED, default 8'hA5: LFSR load value at run start; 8'h00 SHALL be replaced by 8'h01.
REQ-003 SHALL have parameter MISMATCH_W, default 8: width of the mismatch counter.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  run request; sampled only in IDLE or DONE.
REQ-008 q_golden  input  1  Q from the reference lut_ff_mux instance.
REQ-009 q_netlist  input  1  Q from the post-route lut_ff_mux instance.
REQ-010 dut_rst  output  1  active-high reset driven to both DUT instances.
REQ-011 stim_in  output  4  in[3:0] driven to both DUT instances.
REQ-012 stim_mux_sel  output  1  mux_sel driven to both DUT instances.
REQ-013 busy  output  1  high from the start-sampling edge until done rises.
REQ-014 done  output  1  run complete; held until the next start or reset.
REQ-015 pass  output  1  done AND mismatch_cnt==0.
REQ-016 mismatch_cnt  output  MISMATCH_W  saturating count of failed compares.

Function
REQ-017 FSM states SHALL be IDLE, VEC, DRAIN and DONE.
- IDLE/DONE with start=1 -> VEC.
- VEC after last compare -> DRAIN.
- DRAIN after 5 cycles -> DONE.
REQ-018 The start-sampling edge (edge 0) SHALL clear mismatch_cnt, done and pass, load the LFSR, and select vector 0.
REQ-019 Total vectors SHALL be 5+NUM_VECTORS.
- Vector v SHALL be driven during the two cycles following edges 2v and 2v+1.
- The vector SHALL be compared at edge 2v+2.
REQ-020 Vector 0 SHALL drive dut_rst=1, stim_in=0, stim_mux_sel=0; dut_rst SHALL be 0 for all later vectors.
REQ-021 Vectors 1..4 SHALL be, as in/mux_sel: 4'b0100/0, 4'b0100/1, 4'b0001/0, 4'b0001/1.
REQ-022 Random vectors SHALL drive stim_in=lfsr[3:0], stim_mux_sel=lfsr[4].
- The LFSR SHALL advance once, at the edge that ends each random vector.
REQ-023 The LFSR SHALL be 8-bit Fibonacci, shifting left; feedback into bit 0 = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
REQ-024 Each compare SHALL increment mismatch_cnt when q_golden!=q_netlist, saturating at 2^MISMATCH_W-1.
REQ-025 done and pass SHALL register at edge 2(5+NUM_VECTORS)+5; busy SHALL fall at the same edge.
REQ-026 In DRAIN the last vector SHALL be held and no compares SHALL occur.
REQ-027 start while busy SHALL be ignored.
- start in DONE SHALL begin a new run per REQ-018.
- start held high SHALL not retrigger until DONE is reached.
REQ-028 In IDLE the block SHALL drive dut_rst=1, stim_in=0, stim_mux_sel=0.

Reset
REQ-029 rst_n low SHALL, regardless of clk:
- force state=IDLE, dut_rst=1, stim_in=0, stim_mux_sel=0, busy=0, done=0, pass=0, mismatch_cnt=0, LFSR=SEED;
- abort any run in progress with no partial result retained.
REQ-030 After rst_n rises, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-031 q_netlist tied to q_golden, NUM_VECTORS=100, start pulsed -> at edge 215: done=1, pass=1, mismatch_cnt=0, busy=0.
REQ-032 q_netlist = ~q_golden, NUM_VECTORS=100 -> mismatch_cnt=105, pass=0; with MISMATCH_W=4 -> mismatch_cnt=15 (saturated).
REQ-033 Directed check:
- stim_in/mux_sel after edges 2/4/6/8 SHALL be 4/0, 4/1, 1/0, 1/1;
- dut_rst SHALL be 1 only before edge 2.
REQ-034 Random check, SEED=8'hA5:
- vector 5 (after edge 10) SHALL be in=5, mux_sel=0;
- vector 6 (after edge 12) SHALL be in=10, mux_sel=0 (LFSR=8'h4A).
REQ-035 rst_n pulsed low at edge 50 of a run -> immediately busy=0, dut_rst=1, mismatch_cnt=0; start after release -> full run completes with pass=1.
REQ-036 start held high for the whole run -> exactly one run; after done, a new run begins on the next start sample, clearing done and pass at that edge.
